// File: rtl/mult_pkg.sv
// mult_pkg: shared types and partial-product helper for the pipelined multiplier
package mult_pkg;
    typedef enum logic {MODE_UNSIGNED = 1'b0, MODE_SIGNED = 1'b1} mult_mode_e;

    function automatic bit rows_divide(int width, int rows);
        return rows > 0 && width % rows == 0;
    endfunction

    function automatic logic [63:0] row_pp(input logic [31:0] a, input logic b_bit, input int idx,
                                           input logic signed_mode, input logic last, input int width);
        logic [63:0] ext;
        logic [63:0] pp;
        ext = (signed_mode && a[5'(width - 1)]) ? ({32'd0, a} | (~64'd0 << width)) : {32'd0, a};
        pp = b_bit ? ext << idx : 64'd0;
        return (signed_mode && last) ? -pp : pp;
    endfunction
endpackage

// File: rtl/mult_pp_stage.sv
// mult_pp_stage: one pipeline stage adding ROWS partial-product rows to the running accumulator
module mult_pp_stage
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROWS  = 1,
    parameter int TAG_W = 4,
    parameter int IDX   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adv,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  mult_mode_e         mode,
    input  logic [TAG_W-1:0]   tag,
    input  logic               valid,
    output logic [2*WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output mult_mode_e         mode_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic               valid_out
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] part [ROWS+1];

    assign part[0] = acc_in;

    for (genvar j = 0; j < ROWS; j++) begin : g_row
        assign part[j+1] = part[j] + PW'(row_pp(32'(a), b[IDX*ROWS+j], IDX * ROWS + j,
                                                 mode == MODE_SIGNED, IDX * ROWS + j == WIDTH - 1, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out   <= '0;
            a_out     <= '0;
            b_out     <= '0;
            mode_out  <= MODE_UNSIGNED;
            tag_out   <= '0;
            valid_out <= 1'b0;
        end else if (adv) begin
            acc_out   <= part[ROWS];
            a_out     <= a;
            b_out     <= b;
            mode_out  <= mode;
            tag_out   <= tag;
            valid_out <= valid;
        end
    end
endmodule

// File: rtl/mult_pipe_param.sv
// mult_pipe_param: pipelined WIDTHxWIDTH array multiplier with valid/ready flow control and tag
module mult_pipe_param
    import mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 1,
    parameter int TAG_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int  NSTG   = WIDTH / ROWS_PER_STAGE;
    localparam bit  CFG_OK = rows_divide(WIDTH, ROWS_PER_STAGE);

    if (!CFG_OK) begin : g_bad_cfg
        $error("mult_pipe_param: ROWS_PER_STAGE must divide WIDTH");
    end

    logic                 adv;
    logic [2*WIDTH-1:0]   acc   [NSTG+1];
    logic [WIDTH-1:0]     a_s   [NSTG+1];
    logic [WIDTH-1:0]     b_s   [NSTG+1];
    mult_mode_e           mode_s[NSTG+1];
    logic [TAG_W-1:0]     tag_s [NSTG+1];
    logic                 vld_s [NSTG+1];

    assign adv       = !out_valid || out_ready;
    assign in_ready  = rst || adv;
    assign acc[0]    = '0;
    assign a_s[0]    = in_a;
    assign b_s[0]    = in_b;
    assign mode_s[0] = mult_mode_e'(in_signed);
    assign tag_s[0]  = in_tag;
    assign vld_s[0]  = in_valid;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        mult_pp_stage #(
            .WIDTH(WIDTH),
            .ROWS (ROWS_PER_STAGE),
            .TAG_W(TAG_W),
            .IDX  (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .acc_in   (acc[k]),
            .a        (a_s[k]),
            .b        (b_s[k]),
            .mode     (mode_s[k]),
            .tag      (tag_s[k]),
            .valid    (vld_s[k]),
            .acc_out  (acc[k+1]),
            .a_out    (a_s[k+1]),
            .b_out    (b_s[k+1]),
            .mode_out (mode_s[k+1]),
            .tag_out  (tag_s[k+1]),
            .valid_out(vld_s[k+1])
        );
    end

    assign out_valid = vld_s[NSTG];
    assign out_prod  = acc[NSTG];
    assign out_tag   = tag_s[NSTG];
endmodule

// File: tb/tb_mult_pipe_param.sv
// tb_mult_pipe_param: directed checks on an 8x8 single-row pipeline plus a scoreboarded 2-row variant
module tb_mult_pipe_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_prod;
    logic [3:0]  out_tag;
    logic        v2 = 1'b0, s2 = 1'b0, or2 = 1'b1;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [3:0]  t2 = '0;
    logic        rdy2, ov2;
    logic [15:0] op2;
    logic [3:0]  ot2;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] sb_q[$];

    always #5 clk = ~clk;

    mult_pipe_param #(.WIDTH(8), .ROWS_PER_STAGE(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_tag(out_tag)
    );

    mult_pipe_param #(.WIDTH(8), .ROWS_PER_STAGE(2), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_a(a2), .in_b(b2),
        .in_signed(s2), .in_tag(t2), .out_valid(ov2), .out_ready(or2),
        .out_prod(op2), .out_tag(ot2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = s ? {{8{a[7]}}, a} : {8'd0, a};
        sb = s ? {{8{b[7]}}, b} : {8'd0, b};
        return 16'(sa * sb);
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
        in_a = a;
        in_b = b;
        in_signed = s;
        in_tag = t;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick;
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                           input logic [3:0] t, input logic [15:0] exp);
        int lat;
        drive(a, b, s, t);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_prod"}, 32'(out_prod), 32'(exp));
        check({tag, "_tag"}, 32'(out_tag), 32'(t));
        tick;
    endtask

    task automatic account2;
        logic [19:0] e;
        @(negedge clk);
        if (v2 && rdy2) sb_q.push_back({t2, model(a2, b2, s2)});
        if (ov2 && or2) begin
            if (sb_q.size() == 0) check("r2_underflow", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                check("r2_prod", 32'(op2), 32'(e[15:0]));
                check("r2_tag", 32'(ot2), 32'(e[19:16]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int lat;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_prod", 32'(out_prod), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid2", 32'(ov2), 32'd0);
        tick;
        run_one("u255", 8'd255, 8'd255, 1'b0, 4'd5, 16'hFE01);
        run_one("s_min2", 8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
        run_one("s_m1x1", 8'hFF, 8'h01, 1'b1, 4'd2, 16'hFFFF);
        run_one("s_maxmin", 8'h7F, 8'h80, 1'b1, 4'd3, 16'hC080);
        run_one("u_min2", 8'h80, 8'h80, 1'b0, 4'd4, 16'h4000);
        drive(8'd3, 8'd5, 1'b0, 4'd1);
        drive(8'hFD, 8'd5, 1'b1, 4'd2);
        drive(8'd200, 8'd2, 1'b0, 4'd3);
        wait_out("bb_wait");
        check("bb0_prod", 32'(out_prod), 32'h000F);
        check("bb0_tag", 32'(out_tag), 32'd1);
        tick;
        check("bb1_valid", 32'(out_valid), 32'd1);
        check("bb1_prod", 32'(out_prod), 32'hFFF1);
        check("bb1_tag", 32'(out_tag), 32'd2);
        tick;
        check("bb2_valid", 32'(out_valid), 32'd1);
        check("bb2_prod", 32'(out_prod), 32'd400);
        check("bb2_tag", 32'(out_tag), 32'd3);
        tick;
        check("bb_end", 32'(out_valid), 32'd0);
        drive(8'd10, 8'd10, 1'b0, 4'd6);
        drive(8'd7, 8'd9, 1'b0, 4'd7);
        drive(8'hFE, 8'd3, 1'b1, 4'd8);
        drive(8'd255, 8'd1, 1'b0, 4'd9);
        wait_out("st_wait");
        out_ready = 1'b0;
        #1;
        check("st_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("st_hold_valid", 32'(out_valid), 32'd1);
            check("st_hold_prod", 32'(out_prod), 32'h0064);
            check("st_hold_tag", 32'(out_tag), 32'd6);
            check("st_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("st_rel_ready", 32'(in_ready), 32'd1);
        check("st0_prod", 32'(out_prod), 32'h0064);
        check("st0_tag", 32'(out_tag), 32'd6);
        tick;
        check("st1_prod", 32'(out_prod), 32'h003F);
        check("st1_tag", 32'(out_tag), 32'd7);
        tick;
        check("st2_prod", 32'(out_prod), 32'hFFFA);
        check("st2_tag", 32'(out_tag), 32'd8);
        tick;
        check("st3_prod", 32'(out_prod), 32'h00FF);
        check("st3_tag", 32'(out_tag), 32'd9);
        tick;
        check("st_end", 32'(out_valid), 32'd0);
        drive(8'd11, 8'd11, 1'b0, 4'd1);
        drive(8'd12, 8'd12, 1'b0, 4'd2);
        drive(8'd13, 8'd13, 1'b0, 4'd3);
        drive(8'd14, 8'd14, 1'b0, 4'd4);
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 8'd9;
        in_b = 8'd9;
        #1;
        check("rr_ready", 32'(in_ready), 32'd1);
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rr_valid", 32'(out_valid), 32'd0);
        check("rr_prod", 32'(out_prod), 32'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (out_valid) cnt++;
        end
        check("rr_stale", 32'(cnt), 32'd0);
        a2 = 8'hFD;
        b2 = 8'hFD;
        s2 = 1'b1;
        t2 = 4'd7;
        v2 = 1'b1;
        tick;
        v2 = 1'b0;
        lat = 1;
        while (!ov2 && lat < 20) begin
            tick;
            lat++;
        end
        check("r2_lat", 32'(lat), 32'd4);
        check("r2_lat_prod", 32'(op2), 32'd9);
        check("r2_lat_tag", 32'(ot2), 32'd7);
        tick;
        for (int c = 0; c < 400; c++) begin
            v2 = ($urandom_range(0, 3) != 0);
            a2 = (c % 16 == 0) ? 8'h80 : 8'($urandom);
            b2 = (c % 16 == 0) ? 8'h80 : (c % 16 == 1) ? 8'hFF : 8'($urandom);
            s2 = 1'($urandom);
            t2 = 4'($urandom);
            or2 = ($urandom_range(0, 3) != 0);
            account2;
        end
        v2 = 1'b0;
        or2 = 1'b1;
        for (int c = 0; c < 12; c++) account2;
        check("r2_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
